write_through_buffer: RTL and testbench
=======================================

# write_through_buffer

Posted-write FIFO between the L1 data cache memory port and main memory. It absorbs the cache's write-through stores and acknowledges them immediately, which removes the per-store memory stall. Stores are drained to memory in order. Reads are forwarded only once every older store has reached memory, so read-after-write ordering holds without address comparison.

## Interface
Parameters:
- DEPTH, 4: number of buffered write entries (power of two).
- PTR_BITS, 2: log2(DEPTH).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- up_address  input  32  cache request address.
- up_write_data  input  32  cache store data.
- up_byte_enable  input  4  cache byte lanes.
- up_write_enable  input  1  1 = store, 0 = read.
- up_request  input  1  cache request valid; held until up_ready.
- up_read_data  output  32  read data to cache.
- up_ready  output  1  one-cycle completion pulse for the current upstream request.
- mem_address  output  32  memory address.
- mem_write_data  output  32  memory store data.
- mem_byte_enable  output  4  memory byte lanes.
- mem_write_enable  output  1  memory write strobe.
- mem_request  output  1  memory request; held stable until mem_ready.
- mem_read_data  input  32  memory read data.
- mem_ready  input  1  memory completion pulse.
- empty  output  1  1 when no stores are buffered and no drain is in flight (used for fences).

## Operation
- Storage is a circular FIFO of {address[31:0], data[31:0], byte_enable[3:0]}.
  - head and tail pointers are PTR_BITS wide and wrap modulo DEPTH.
  - count is PTR_BITS+1 bits wide, range 0..DEPTH.
- Store accept: when up_request=1 and up_write_enable=1 and count<DEPTH:
  - up_ready=1 in the same cycle.
  - The entry is written at the tail, tail increments, count increments.
- Store stall: when count==DEPTH, up_ready=0. This holds even if a pop occurs in the same cycle; the store is accepted in the next cycle.
- Downstream ownership uses a registered FSM with states IDLE, DRAIN and READ.
  - IDLE with count!=0: drive the head entry on mem_*, with mem_request=1 and mem_write_enable=1.
    - If mem_ready=1: pop and stay in IDLE.
    - Else: go to DRAIN.
  - DRAIN: keep driving the head entry unchanged. On mem_ready: pop and go to IDLE.
  - IDLE with count==0, up_request=1 and up_write_enable=0: pass the read through to memory.
    - mem_address=up_address, mem_byte_enable=up_byte_enable, mem_write_enable=0, mem_request=1.
    - up_read_data=mem_read_data and up_ready=mem_ready, both combinational.
    - Stay in IDLE if mem_ready=1; else go to READ.
  - READ: continue the pass-through. On mem_ready: go to IDLE.
- A read that arrives while count!=0 waits with up_ready=0 until the FIFO is empty and the FSM is in IDLE. Drains always take priority over reads.
- A store pushed in cycle t becomes visible to the drain logic at t+1. An empty FIFO therefore never bypasses a store combinationally.
- Simultaneous push and pop with count<DEPTH: both take effect and count is unchanged.
- When the port is not driven: mem_* = 0, up_read_data = 0.
- empty = (count==0) && (state==IDLE).

## Timing
- Reset (asynchronous, rst=1):
  - head, tail and count = 0; state = IDLE.
  - All mem_* outputs = 0, up_ready = 0, up_read_data = 0, empty = 1.
  - Buffered stores are discarded. An in-flight memory transaction is abandoned and mem_request drops immediately.
- Store latency to the cache is 0 cycles (same-cycle ack) when not full.
- Store latency to memory is at least 1 cycle after the ack, plus any backlog ahead of it.
- Read latency equals the memory latency plus the drain time of all buffered stores.
- Throughput: one store accepted per cycle. One store retired per mem_ready pulse.

## Test plan
- Reset: assert rst mid-cycle -> all outputs read 0 and empty=1 without waiting for a clk edge.
- Single store, mem_ready one cycle after request:
  - Stimulus: store 0xDEADBEEF to 0x100, be=4'b1111, at cycle 0.
  - Response: up_ready=1 at cycle 0; mem_request=1 with 0x100/0xDEADBEEF/write at cycle 1, held through cycle 2 when mem_ready=1; empty=1 at cycle 3.
- Full:
  - Stimulus: five back-to-back stores to 0x0, 0x4, 0x8, 0xC, 0x10 with mem_ready held 0.
  - Response: the first four are acked in cycles 0-3; the fifth stalls. After one mem_ready pulse, the fifth is acked the following cycle. Memory sees addresses in order 0x0, 0x4, 0x8, 0xC, 0x10.
- Read after writes:
  - Stimulus: stores to 0x200 and 0x204, then a read of 0x200.
  - Response: mem sees W 0x200, W 0x204, R 0x200 in that order; the read's up_ready occurs only after the second write's mem_ready; up_read_data equals mem_read_data in that cycle.
- Read with empty buffer and mem_ready=1 in the request cycle -> up_ready=1 and up_read_data=mem_read_data in the same cycle; state stays IDLE.
- Pointer wrap: 10 stores with mem_ready alternating 1/0 -> every store reaches memory exactly once, in order, and count never exceeds 4.

Source files
------------

// File: rtl/write_through_buffer_if.sv
// ============================================================================
//  write_through_buffer_if : cache-side and memory-side bus bundle
//  Rev 1.0
// ============================================================================
`default_nettype none

interface write_through_buffer_if;
   logic [31:0] up_address;
   logic [31:0] up_write_data;
   logic [3:0]  up_byte_enable;
   logic        up_write_enable;
   logic        up_request;
   logic [31:0] up_read_data;
   logic        up_ready;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_byte_enable;
   logic        mem_write_enable;
   logic        mem_request;
   logic [31:0] mem_read_data;
   logic        mem_ready;
   logic        empty;

   // slave: the buffer itself; master: the cache/memory environment around it
   modport slave (
      input  up_address, up_write_data, up_byte_enable, up_write_enable, up_request,
      input  mem_read_data, mem_ready,
      output up_read_data, up_ready,
      output mem_address, mem_write_data, mem_byte_enable, mem_write_enable, mem_request,
      output empty
   );

   modport master (
      output up_address, up_write_data, up_byte_enable, up_write_enable, up_request,
      output mem_read_data, mem_ready,
      input  up_read_data, up_ready,
      input  mem_address, mem_write_data, mem_byte_enable, mem_write_enable, mem_request,
      input  empty
   );
endinterface

`default_nettype wire

// File: rtl/write_through_buffer.sv
// ============================================================================
//  write_through_buffer : posted-write FIFO between L1 cache and main memory
//  Rev 1.0
// ============================================================================
`default_nettype none

module write_through_buffer #(
   parameter int DEPTH    = 4,
   parameter int PTR_BITS = 2
) (
   input  wire logic               clk,
   input  wire logic               rst,
   write_through_buffer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      READ  = 2'd2
   } state_t;

   localparam logic [PTR_BITS:0]   C_FULL    = (PTR_BITS+1)'(DEPTH);
   localparam logic [PTR_BITS:0]   C_CNT_ONE = (PTR_BITS+1)'(1);
   localparam logic [PTR_BITS-1:0] C_PTR_ONE = PTR_BITS'(1);

   state_t              state_q, state_d;
   logic [PTR_BITS-1:0] head_q, head_d;
   logic [PTR_BITS-1:0] tail_q, tail_d;
   logic [PTR_BITS:0]   count_q, count_d;

   logic [31:0] addr_mem [DEPTH];
   logic [31:0] data_mem [DEPTH];
   logic [3:0]  be_mem   [DEPTH];

   logic push, pop, drive_head, fwd_read;

   // Control is forced idle during reset so every output reads zero immediately.
   always_comb begin
      state_d    = state_q;
      push       = 1'b0;
      pop        = 1'b0;
      drive_head = 1'b0;
      fwd_read   = 1'b0;
      if (!rst) begin
         push = bus.up_request && bus.up_write_enable && (count_q != C_FULL);
         unique case (state_q)
            IDLE: begin
               if (count_q != '0) begin
                  drive_head = 1'b1;
                  if (bus.mem_ready) pop = 1'b1;
                  else               state_d = DRAIN;
               end else if (bus.up_request && !bus.up_write_enable) begin
                  fwd_read = 1'b1;
                  if (!bus.mem_ready) state_d = READ;
               end
            end
            DRAIN: begin
               drive_head = 1'b1;
               if (bus.mem_ready) begin
                  pop     = 1'b1;
                  state_d = IDLE;
               end
            end
            READ: begin
               fwd_read = 1'b1;
               if (bus.mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.mem_address      = '0;
      bus.mem_write_data   = '0;
      bus.mem_byte_enable  = '0;
      bus.mem_write_enable = 1'b0;
      bus.mem_request      = 1'b0;
      bus.up_read_data     = '0;
      if (drive_head) begin
         bus.mem_address      = addr_mem[head_q];
         bus.mem_write_data   = data_mem[head_q];
         bus.mem_byte_enable  = be_mem[head_q];
         bus.mem_write_enable = 1'b1;
         bus.mem_request      = 1'b1;
      end else if (fwd_read) begin
         bus.mem_address      = bus.up_address;
         bus.mem_byte_enable  = bus.up_byte_enable;
         bus.mem_request      = 1'b1;
         bus.up_read_data     = bus.mem_read_data;
      end
      bus.up_ready = push || (fwd_read && bus.mem_ready);
      bus.empty    = (count_q == '0) && (state_q == IDLE);
   end

   always_comb begin
      head_d  = pop  ? head_q + C_PTR_ONE : head_q;
      tail_d  = push ? tail_q + C_PTR_ONE : tail_q;
      count_d = count_q;
      if (push && !pop)      count_d = count_q + C_CNT_ONE;
      else if (pop && !push) count_d = count_q - C_CNT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset: only entries inside [head, tail) are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail_q] <= bus.up_address;
         data_mem[tail_q] <= bus.up_write_data;
         be_mem[tail_q]   <= bus.up_byte_enable;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_write_through_buffer.sv
// ============================================================================
//  tb_write_through_buffer : directed and randomized checks against a queue model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_write_through_buffer;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } store_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   write_through_buffer_if bus_if ();

   write_through_buffer #(.DEPTH(4), .PTR_BITS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus_if.up_address      = '0;
      bus_if.up_write_data   = '0;
      bus_if.up_byte_enable  = '0;
      bus_if.up_write_enable = 1'b0;
      bus_if.up_request      = 1'b0;
      bus_if.mem_read_data   = '0;
      bus_if.mem_ready       = 1'b0;
   endtask

   task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      bus_if.up_address      = a;
      bus_if.up_write_data   = d;
      bus_if.up_byte_enable  = be;
      bus_if.up_write_enable = 1'b1;
      bus_if.up_request      = 1'b1;
   endtask

   task automatic test_reset();
      logic [3:0]  flags;
      logic [99:0] buses;
      idle_inputs();
      rst = 1'b1;
      #2;
      flags = {bus_if.mem_request, bus_if.mem_write_enable, bus_if.up_ready, bus_if.empty};
      checks++;
      if (flags !== 4'b0001) begin
         errors++; $display("FAIL reset_flags got %b want 0001", flags);
      end
      buses = {bus_if.mem_address, bus_if.mem_write_data, bus_if.mem_byte_enable, bus_if.up_read_data};
      checks++;
      if (buses !== '0) begin
         errors++; $display("FAIL reset_buses got %h want 0", buses);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      drive_store(32'h55, 32'h1234_5678, 4'hF);
      #1;
      checks++;
      if (bus_if.up_ready !== 1'b1) begin
         errors++; $display("FAIL reset_pre_store_ack got %b want 1", bus_if.up_ready);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (bus_if.mem_request !== 1'b1) begin
         errors++; $display("FAIL reset_pre_drain got %b want 1", bus_if.mem_request);
      end
      // Assert reset mid-cycle with a store still requesting.
      drive_store(32'h99, 32'h0, 4'h1);
      #1;
      rst = 1'b1;
      #1;
      flags = {bus_if.mem_request, bus_if.mem_write_enable, bus_if.up_ready, bus_if.empty};
      checks++;
      if (flags !== 4'b0001) begin
         errors++; $display("FAIL reset_async_flags got %b want 0001", flags);
      end
      checks++;
      if (bus_if.mem_address !== 32'h0) begin
         errors++; $display("FAIL reset_async_addr got %h want 0", bus_if.mem_address);
      end
      idle_inputs();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_store();
      drive_store(32'h100, 32'hDEAD_BEEF, 4'b1111);
      #2;
      checks++;
      if ({bus_if.up_ready, bus_if.mem_request} !== 2'b10) begin
         errors++; $display("FAIL single_c0 got ready/req %b want 10", {bus_if.up_ready, bus_if.mem_request});
      end
      tick();
      idle_inputs();
      #2;
      checks++;
      if ({bus_if.mem_request, bus_if.mem_write_enable, bus_if.mem_address, bus_if.mem_write_data, bus_if.mem_byte_enable}
          !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF}) begin
         errors++; $display("FAIL single_c1 got req %b addr %h data %h want 1 100 deadbeef",
                            bus_if.mem_request, bus_if.mem_address, bus_if.mem_write_data);
      end
      tick();
      bus_if.mem_ready = 1'b1;
      #2;
      checks++;
      if ({bus_if.mem_request, bus_if.mem_address, bus_if.mem_write_data} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL single_c2 got req %b addr %h want 1 100", bus_if.mem_request, bus_if.mem_address);
      end
      tick();
      bus_if.mem_ready = 1'b0;
      #2;
      checks++;
      if ({bus_if.empty, bus_if.mem_request} !== 2'b10) begin
         errors++; $display("FAIL single_c3 got empty/req %b want 10", {bus_if.empty, bus_if.mem_request});
      end
      tick();
   endtask

   task automatic test_full();
      logic [31:0] seen [$];
      logic [31:0] exp_addr;
      int          n;
      for (int i = 0; i < 5; i++) begin
         drive_store(32'(4 * i), 32'(i + 7), 4'hF);
         #2;
         checks++;
         if (bus_if.up_ready !== (i < 4)) begin
            errors++; $display("FAIL full_ack_%0d got %b want %b", i, bus_if.up_ready, (i < 4));
         end
         tick();
      end
      bus_if.mem_ready = 1'b1;
      #2;
      checks++;
      if (bus_if.up_ready !== 1'b0) begin
         errors++; $display("FAIL full_stall_on_pop got %b want 0", bus_if.up_ready);
      end
      if (bus_if.mem_request === 1'b1) seen.push_back(bus_if.mem_address);
      tick();
      bus_if.mem_ready = 1'b0;
      #2;
      checks++;
      if (bus_if.up_ready !== 1'b1) begin
         errors++; $display("FAIL full_late_ack got %b want 1", bus_if.up_ready);
      end
      tick();
      idle_inputs();
      n = 0;
      while (seen.size() < 5 && n < 40) begin
         bus_if.mem_ready = 1'b1;
         #2;
         if (bus_if.mem_request === 1'b1) seen.push_back(bus_if.mem_address);
         tick();
         n++;
      end
      idle_inputs();
      checks++;
      if (seen.size() != 5) begin
         errors++; $display("FAIL full_drain_count got %0d want 5", seen.size());
      end
      for (int i = 0; i < 5 && i < seen.size(); i++) begin
         exp_addr = 32'(4 * i);
         checks++;
         if (seen[i] !== exp_addr) begin
            errors++; $display("FAIL full_order_%0d got %h want %h", i, seen[i], exp_addr);
         end
      end
      tick();
   endtask

   task automatic test_raw();
      logic [32:0] log_q [$];
      logic        seen;
      logic        done;
      int          n;
      drive_store(32'h200, 32'hAAAA_0001, 4'hF);
      #2;
      checks++;
      if (bus_if.up_ready !== 1'b1) begin
         errors++; $display("FAIL raw_ack0 got %b want 1", bus_if.up_ready);
      end
      tick();
      drive_store(32'h204, 32'hAAAA_0002, 4'hF);
      #2;
      checks++;
      if (bus_if.up_ready !== 1'b1) begin
         errors++; $display("FAIL raw_ack1 got %b want 1", bus_if.up_ready);
      end
      tick();
      bus_if.up_address      = 32'h200;
      bus_if.up_byte_enable  = 4'hF;
      bus_if.up_write_enable = 1'b0;
      bus_if.up_request      = 1'b1;
      seen = 1'b0;
      done = 1'b0;
      n    = 0;
      while (!done && n < 30) begin
         bus_if.mem_read_data = $urandom;
         bus_if.mem_ready     = 1'b0;
         #1;
         if (bus_if.mem_request === 1'b1) begin
            if (seen) begin
               bus_if.mem_ready = 1'b1;
               seen = 1'b0;
            end else begin
               seen = 1'b1;
            end
         end
         #1;
         if (bus_if.mem_ready) log_q.push_back({bus_if.mem_write_enable, bus_if.mem_address});
         if (bus_if.mem_ready && !bus_if.mem_write_enable) begin
            checks++;
            if ({bus_if.up_ready, bus_if.up_read_data} !== {1'b1, bus_if.mem_read_data}) begin
               errors++; $display("FAIL raw_read_done got rdy %b data %h want 1 %h",
                                  bus_if.up_ready, bus_if.up_read_data, bus_if.mem_read_data);
            end
            done = 1'b1;
         end else begin
            checks++;
            if (bus_if.up_ready !== 1'b0) begin
               errors++; $display("FAIL raw_read_early got %b want 0 (log size %0d)", bus_if.up_ready, log_q.size());
            end
         end
         tick();
         n++;
      end
      idle_inputs();
      checks++;
      if (log_q.size() != 3) begin
         errors++; $display("FAIL raw_log_size got %0d want 3", log_q.size());
      end else begin
         checks++;
         if ({log_q[0], log_q[1], log_q[2]} !== {1'b1, 32'h200, 1'b1, 32'h204, 1'b0, 32'h200}) begin
            errors++; $display("FAIL raw_order got %h %h %h want 1_200 1_204 0_200", log_q[0], log_q[1], log_q[2]);
         end
      end
      tick();
   endtask

   task automatic test_read_empty();
      logic [31:0] rd;
      rd = $urandom;
      bus_if.up_address      = 32'h300;
      bus_if.up_byte_enable  = 4'h3;
      bus_if.up_write_enable = 1'b0;
      bus_if.up_request      = 1'b1;
      bus_if.mem_ready       = 1'b1;
      bus_if.mem_read_data   = rd;
      #2;
      checks++;
      if ({bus_if.up_ready, bus_if.up_read_data, bus_if.mem_request, bus_if.mem_write_enable,
           bus_if.mem_address, bus_if.mem_byte_enable} !== {1'b1, rd, 1'b1, 1'b0, 32'h300, 4'h3}) begin
         errors++; $display("FAIL read_empty got rdy %b data %h req %b we %b addr %h want 1 %h 1 0 300",
                            bus_if.up_ready, bus_if.up_read_data, bus_if.mem_request,
                            bus_if.mem_write_enable, bus_if.mem_address, rd);
      end
      tick();
      idle_inputs();
      #2;
      checks++;
      if ({bus_if.empty, bus_if.mem_request} !== 2'b10) begin
         errors++; $display("FAIL read_empty_idle got empty/req %b want 10", {bus_if.empty, bus_if.mem_request});
      end
      tick();
   endtask

   task automatic test_wrap();
      int acked = 0;
      int retired = 0;
      int max_out = 0;
      int n = 0;
      logic [31:0] exp_addr;
      while (retired < 10 && n < 200) begin
         if (acked < 10) drive_store(32'h1000 + 32'(4 * acked), 32'(acked), 4'hF);
         else            bus_if.up_request = 1'b0;
         bus_if.mem_ready = (n % 2 == 0);
         #2;
         if (bus_if.mem_request === 1'b1 && bus_if.mem_ready) begin
            exp_addr = 32'h1000 + 32'(4 * retired);
            checks++;
            if ({bus_if.mem_write_enable, bus_if.mem_address, bus_if.mem_write_data} !== {1'b1, exp_addr, 32'(retired)}) begin
               errors++; $display("FAIL wrap_retire_%0d got addr %h data %h want %h %h",
                                  retired, bus_if.mem_address, bus_if.mem_write_data, exp_addr, retired);
            end
            retired++;
         end
         if (bus_if.up_ready === 1'b1 && acked < 10) acked++;
         if (acked - retired > max_out) max_out = acked - retired;
         tick();
         n++;
      end
      idle_inputs();
      checks++;
      if ({acked, retired} !== {32'd10, 32'd10}) begin
         errors++; $display("FAIL wrap_totals got acked %0d retired %0d want 10 10", acked, retired);
      end
      checks++;
      if (max_out > 4) begin
         errors++; $display("FAIL wrap_occupancy got %0d want <=4", max_out);
      end
      #2;
      checks++;
      if ({bus_if.empty, bus_if.mem_request} !== 2'b10) begin
         errors++; $display("FAIL wrap_final got empty/req %b want 10", {bus_if.empty, bus_if.mem_request});
      end
      tick();
   endtask

   task automatic test_random();
      store_t      q [$];
      store_t      req;
      store_t      s;
      logic        req_active = 1'b0;
      logic        req_we     = 1'b0;
      logic        read_pending = 1'b0;
      logic        exp_push, exp_fwd, exp_rdy, exp_req, exp_we, exp_empty;
      logic [31:0] exp_addr, exp_wdata, exp_rdata;
      logic [3:0]  exp_be;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (!req_active && $urandom_range(0, 3) != 0) begin
            req_active = 1'b1;
            req_we     = ($urandom_range(0, 9) < 7);
            req.addr   = $urandom & 32'hFFFF_FFFC;
            req.data   = $urandom;
            req.be     = 4'($urandom);
         end
         bus_if.up_request      = req_active;
         bus_if.up_write_enable = req_we;
         bus_if.up_address      = req.addr;
         bus_if.up_write_data   = req.data;
         bus_if.up_byte_enable  = req.be;
         bus_if.mem_ready       = 1'($urandom_range(0, 1));
         bus_if.mem_read_data   = $urandom;
         #2;
         // Reference: stores sit in a queue; memory sees its head, else the waiting read.
         exp_push  = req_active && req_we && (q.size() < 4);
         exp_fwd   = 1'b0;
         exp_req   = 1'b0; exp_we = 1'b0;
         exp_addr  = '0; exp_wdata = '0; exp_be = '0; exp_rdata = '0;
         if (q.size() > 0) begin
            exp_req = 1'b1; exp_we = 1'b1;
            exp_addr = q[0].addr; exp_wdata = q[0].data; exp_be = q[0].be;
         end else if (req_active && !req_we) begin
            exp_fwd = 1'b1; exp_req = 1'b1;
            exp_addr = req.addr; exp_be = req.be; exp_rdata = bus_if.mem_read_data;
         end
         exp_rdy   = exp_push || (exp_fwd && bus_if.mem_ready);
         exp_empty = (q.size() == 0) && !read_pending;
         checks++;
         if ({bus_if.up_ready, bus_if.mem_request, bus_if.mem_write_enable, bus_if.empty}
             !== {exp_rdy, exp_req, exp_we, exp_empty}) begin
            errors++; $display("FAIL rand_ctrl cyc %0d got rdy/req/we/empty %b want %b", cyc,
                               {bus_if.up_ready, bus_if.mem_request, bus_if.mem_write_enable, bus_if.empty},
                               {exp_rdy, exp_req, exp_we, exp_empty});
         end
         checks++;
         if ({bus_if.mem_address, bus_if.mem_write_data, bus_if.mem_byte_enable, bus_if.up_read_data}
             !== {exp_addr, exp_wdata, exp_be, exp_rdata}) begin
            errors++; $display("FAIL rand_data cyc %0d got %h %h %h %h want %h %h %h %h", cyc,
                               bus_if.mem_address, bus_if.mem_write_data, bus_if.mem_byte_enable,
                               bus_if.up_read_data, exp_addr, exp_wdata, exp_be, exp_rdata);
         end
         if (q.size() > 0 && bus_if.mem_ready) void'(q.pop_front());
         if (exp_push) begin
            s = req;
            q.push_back(s);
         end
         if (exp_fwd) read_pending = !bus_if.mem_ready;
         if (exp_rdy) req_active = 1'b0;
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_store();
      test_full();
      test_raw();
      test_read_empty();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
